// File: rtl/key_debouncer_pkg.sv
// Shared constants and helpers for the push-button debouncer.
// Key states are normalised so that pressed is always 1, whatever the pin polarity.
package key_debouncer_pkg;

    localparam int unsigned CLK_HZ_DEFAULT = 50_000_000;

    typedef enum logic {
        KEY_RELEASED = 1'b0,
        KEY_PRESSED  = 1'b1
    } key_state_e;

    function automatic int unsigned ms_to_cycles(input int unsigned clk_hz,
                                                 input int unsigned ms);
        return clk_hz / 1000 * ms;
    endfunction

endpackage

// File: rtl/key_debouncer_debounce_1.sv
// Single-key synchroniser, debounce counter and long-press hold counter.
// Outputs are registered; press and release pulses share the edge that updates the level.
module key_debounce_1
    import key_debouncer_pkg::*;
#(
    parameter int unsigned DB_CYC      = 5,
    parameter int unsigned LONG_CYC    = 20,
    parameter int unsigned KEY_ACT_LOW = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_pin,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic long_o
);

    localparam int unsigned DW = $clog2(DB_CYC + 1);
    localparam int unsigned HW = $clog2(LONG_CYC + 1);
    localparam logic [DW-1:0] DB_LAST   = DW'(DB_CYC - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYC - 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_CYC);
    localparam logic          PIN_IDLE  = (KEY_ACT_LOW != 0) ? 1'b1 : 1'b0;

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    key_state_e    level_q, level_d;
    key_state_e    sample_st;
    logic [DW-1:0] db_cnt_q, db_cnt_d;
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    logic          press_q, press_d;
    logic          release_q, release_d;
    logic          long_q, long_d;

    always_comb begin
        sync1_d    = key_pin;
        sync2_d    = sync1_q;
        sample_st  = ((sync2_q ^ PIN_IDLE) == 1'b1) ? KEY_PRESSED : KEY_RELEASED;
        level_d    = level_q;
        db_cnt_d   = '0;
        press_d    = 1'b0;
        release_d  = 1'b0;
        hold_cnt_d = '0;
        long_d     = 1'b0;

        // Any cycle of agreement drops the counter back to zero.
        if (sample_st != level_q) begin
            if (db_cnt_q == DB_LAST) begin
                level_d   = sample_st;
                press_d   = (sample_st == KEY_PRESSED);
                release_d = (sample_st == KEY_RELEASED);
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end

        if (level_q == KEY_PRESSED) begin
            hold_cnt_d = (hold_cnt_q != HOLD_MAX) ? hold_cnt_q + 1'b1 : hold_cnt_q;
            long_d     = (hold_cnt_q == HOLD_LAST);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q    <= PIN_IDLE;
            sync2_q    <= PIN_IDLE;
            level_q    <= KEY_RELEASED;
            db_cnt_q   <= '0;
            hold_cnt_q <= '0;
            press_q    <= 1'b0;
            release_q  <= 1'b0;
            long_q     <= 1'b0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            level_q    <= level_d;
            db_cnt_q   <= db_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            press_q    <= press_d;
            release_q  <= release_d;
            long_q     <= long_d;
        end
    end

    assign level_o   = (level_q == KEY_PRESSED);
    assign press_o   = press_q;
    assign release_o = release_q;
    assign long_o    = long_q;

endmodule

// File: rtl/key_debouncer.sv
// Board push-button front end: NUM_KEYS independent debouncers on CLOCK_50.
// Emits clean levels plus press, release and long-press pulses per key.
module key_debouncer
    import key_debouncer_pkg::*;
#(
    parameter int unsigned NUM_KEYS    = 4,
    parameter int unsigned CLK_HZ      = CLK_HZ_DEFAULT,
    parameter int unsigned DEBOUNCE_MS = 20,
    parameter int unsigned LONG_MS     = 1000,
    parameter int unsigned KEY_ACT_LOW = 1
) (
    input  logic                CLOCK_50,
    input  logic                RST_N,
    input  logic [NUM_KEYS-1:0] KEY,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic [NUM_KEYS-1:0] key_long
);

    localparam int unsigned DB_CYC   = ms_to_cycles(CLK_HZ, DEBOUNCE_MS);
    localparam int unsigned LONG_CYC = ms_to_cycles(CLK_HZ, LONG_MS);

    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
        key_debounce_1 #(
            .DB_CYC      (DB_CYC),
            .LONG_CYC    (LONG_CYC),
            .KEY_ACT_LOW (KEY_ACT_LOW)
        ) u_key (
            .clk       (CLOCK_50),
            .rst_n     (RST_N),
            .key_pin   (KEY[g]),
            .level_o   (key_level[g]),
            .press_o   (key_press[g]),
            .release_o (key_release[g]),
            .long_o    (key_long[g])
        );
    end

endmodule

// File: tb/tb_key_debouncer.sv
// Directed bench for key_debouncer with DB_CYC=5, LONG_CYC=20 (pin->level latency 7).
module tb_key_debouncer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] key;
    logic [3:0] key_level, key_press, key_release, key_long;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    key_debouncer #(
        .NUM_KEYS    (4),
        .CLK_HZ      (1000),
        .DEBOUNCE_MS (5),
        .LONG_MS     (20),
        .KEY_ACT_LOW (1)
    ) dut (
        .CLOCK_50    (clk),
        .RST_N       (rst_n),
        .KEY         (key),
        .key_level   (key_level),
        .key_press   (key_press),
        .key_release (key_release),
        .key_long    (key_long)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        key   = 4'hF;

        // 1: reset
        repeat (4) tick();
        check_eq("rst_level",   32'(key_level),   32'h0);
        check_eq("rst_press",   32'(key_press),   32'h0);
        check_eq("rst_release", 32'(key_release), 32'h0);
        check_eq("rst_long",    32'(key_long),    32'h0);
        rst_n = 1'b1;
        repeat (3) tick();

        // 2: key0 press, exact 7-cycle latency and one-cycle pulse
        key = 4'hE;
        for (int i = 1; i <= 8; i++) begin
            tick();
            check_eq($sformatf("k0_level_%0d", i), 32'(key_level), (i >= 7) ? 32'h1 : 32'h0);
            check_eq($sformatf("k0_press_%0d", i), 32'(key_press), (i == 7) ? 32'h1 : 32'h0);
        end
        key = 4'hF;
        for (int i = 1; i <= 8; i++) begin
            tick();
            check_eq($sformatf("k0_rel_level_%0d", i), 32'(key_level),   (i >= 7) ? 32'h0 : 32'h1);
            check_eq($sformatf("k0_release_%0d", i),   32'(key_release), (i == 7) ? 32'h1 : 32'h0);
            check_eq($sformatf("k0_rel_long_%0d", i),  32'(key_long),    32'h0);
        end

        // 3: key1 bounce shorter than debounce interval
        for (int i = 1; i <= 16; i++) begin
            key = (i <= 8 && ((i - 1) / 2) % 2 == 0) ? 4'hD : 4'hF;
            tick();
            check_eq($sformatf("bounce_level_%0d", i), 32'(key_level),   32'h0);
            check_eq($sformatf("bounce_press_%0d", i), 32'(key_press),   32'h0);
            check_eq($sformatf("bounce_rel_%0d", i),   32'(key_release), 32'h0);
        end

        // 4: key2 long hold, single long pulse, then release
        key = 4'hB;
        for (int i = 1; i <= 35; i++) begin
            tick();
            check_eq($sformatf("k2_level_%0d", i), 32'(key_level), (i >= 7)  ? 32'h4 : 32'h0);
            check_eq($sformatf("k2_press_%0d", i), 32'(key_press), (i == 7)  ? 32'h4 : 32'h0);
            check_eq($sformatf("k2_long_%0d", i),  32'(key_long),  (i == 27) ? 32'h4 : 32'h0);
        end
        key = 4'hF;
        for (int i = 1; i <= 8; i++) begin
            tick();
            check_eq($sformatf("k2_rel_level_%0d", i), 32'(key_level),   (i >= 7) ? 32'h0 : 32'h4);
            check_eq($sformatf("k2_release_%0d", i),   32'(key_release), (i == 7) ? 32'h4 : 32'h0);
            check_eq($sformatf("k2_rel_press_%0d", i), 32'(key_press),   32'h0);
        end

        // 5: key0 and key3 pressed together
        key = 4'h6;
        for (int i = 1; i <= 8; i++) begin
            tick();
            check_eq($sformatf("k03_level_%0d", i), 32'(key_level), (i >= 7) ? 32'h9 : 32'h0);
            check_eq($sformatf("k03_press_%0d", i), 32'(key_press), (i == 7) ? 32'h9 : 32'h0);
        end

        // 6: reset while held, keys re-accepted after reset release
        rst_n = 1'b0;
        tick();
        check_eq("midrst_level", 32'(key_level), 32'h0);
        check_eq("midrst_press", 32'(key_press), 32'h0);
        rst_n = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            check_eq($sformatf("reacc_level_%0d", i), 32'(key_level), (i >= 7) ? 32'h9 : 32'h0);
            check_eq($sformatf("reacc_press_%0d", i), 32'(key_press), (i == 7) ? 32'h9 : 32'h0);
            check_eq($sformatf("reacc_rel_%0d", i),   32'(key_release), 32'h0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
